// File: rtl/booth_pkg.sv
// ---------------------------------------------------------------------------
// booth_pkg
// Shared definitions for the Booth multiplier job sequencer:
//   - seq_state_e   : sequencer FSM states (IDLE, LAUNCH, WAIT, HOLD)
//   - WIDTH_DEF     : default operand width (product is 2*WIDTH)
//   - DEPTH_DEF     : default operand FIFO depth (power of two, >= 2)
//   - TAG_W_DEF     : default job tag width
//   - TIMEOUT_LIMIT : watchdog terminal count used when BOOTH_SEQ_TIMEOUT_EN
//                     is defined
//   - WDOG_W        : watchdog counter width (holds 0..TIMEOUT_LIMIT)
// ---------------------------------------------------------------------------
package booth_pkg;

    localparam int WIDTH_DEF     = 8;
    localparam int DEPTH_DEF     = 4;
    localparam int TAG_W_DEF     = 2;
    localparam int TIMEOUT_LIMIT = 63;
    localparam int WDOG_W        = 6;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_HOLD   = 2'd3
    } seq_state_e;

endpackage

// File: rtl/booth_op_fifo.sv
// ---------------------------------------------------------------------------
// booth_op_fifo
// Synchronous FIFO holding packed {tag, a, b} operand jobs.
// Ports:
//   clock, reset      : rising-edge clock, asynchronous active-high reset
//   push, push_data   : write request and data (ignored when full)
//   pop               : read request (ignored when empty)
//   pop_data          : head entry, valid whenever empty is low
//   full, empty       : occupancy flags
// Pointers wrap modulo DEPTH; the count carries one extra bit so that the
// full and empty cases can be told apart.
// ---------------------------------------------------------------------------
module booth_op_fifo
    import booth_pkg::*;
#(
    parameter int DATA_W = 2 * WIDTH_DEF + TAG_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_data,
    output logic              full,
    output logic              empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]    count_q, count_d;
    logic              push_ok;
    logic              pop_ok;

    assign full     = (count_q == (PTR_W+1)'(DEPTH));
    assign empty    = (count_q == '0);
    assign pop_data = mem_q[rd_ptr_q];

    // Requests against a full or empty FIFO are dropped here so the caller
    // never corrupts the pointers.
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push_ok && !pop_ok) begin
            count_d = count_q + (PTR_W+1)'(1);
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - (PTR_W+1)'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/booth_job_sequencer.sv
// ---------------------------------------------------------------------------
// booth_job_sequencer
// Front-end job sequencer for the Booth multiplier. Operand pairs arrive on
// a valid/ready stream, queue in booth_op_fifo, are launched one at a time
// with a single-cycle mul_start, and the product returns with its tag on a
// valid/ready output stream.
// Ports:
//   clock, reset                  : clock, asynchronous active-high reset
//   in_valid/in_ready             : input handshake (in_ready = FIFO not full)
//   in_a, in_b, in_tag            : signed operands and job tag
//   mul_start                     : one-cycle launch pulse
//   mul_a, mul_b                  : operands, stable from launch to completion
//   mul_done, mul_product         : multiplier done level and result
//   out_valid/out_ready           : output handshake
//   out_product, out_tag, out_err : result, its tag, timeout flag
//   busy                          : FSM not idle or jobs queued
// Configuration macro BOOTH_SEQ_TIMEOUT_EN adds a watchdog that forces an
// error result (product 0, out_err 1) after TIMEOUT_LIMIT cycles in WAIT
// without a done edge. Without it WAIT waits indefinitely and out_err is 0.
// ---------------------------------------------------------------------------
module booth_job_sequencer
    import booth_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int TAG_W = TAG_W_DEF
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               mul_start,
    output logic [WIDTH-1:0]   mul_a,
    output logic [WIDTH-1:0]   mul_b,
    input  logic               mul_done,
    input  logic [2*WIDTH-1:0] mul_product,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_product,
    output logic [TAG_W-1:0]   out_tag,
    output logic               out_err,
    output logic               busy
);

    localparam int JOB_W = TAG_W + 2 * WIDTH;

    seq_state_e         state_q, state_d;
    logic               mul_start_q, mul_start_d;
    logic [WIDTH-1:0]   mul_a_q, mul_a_d;
    logic [WIDTH-1:0]   mul_b_q, mul_b_d;
    logic [TAG_W-1:0]   job_tag_q, job_tag_d;
    logic               done_prev_q;
    logic               out_valid_q, out_valid_d;
    logic [2*WIDTH-1:0] out_product_q, out_product_d;
    logic [TAG_W-1:0]   out_tag_q, out_tag_d;
`ifdef BOOTH_SEQ_TIMEOUT_EN
    logic               out_err_q, out_err_d;
    logic [WDOG_W-1:0]  wdog_q, wdog_d;
`endif

    logic               fifo_push;
    logic               fifo_pop;
    logic [JOB_W-1:0]   fifo_rd_data;
    logic               fifo_full;
    logic               fifo_empty;
    logic               done_rise;

    assign fifo_push = in_valid && !fifo_full;
    assign fifo_pop  = (state_q == ST_IDLE) && !fifo_empty;

    booth_op_fifo #(
        .DATA_W (JOB_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (fifo_push),
        .push_data ({in_tag, in_a, in_b}),
        .pop       (fifo_pop),
        .pop_data  (fifo_rd_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // done may still be high from the previous job when the next one is
    // launched, so only a 0->1 transition counts as completion.
    assign done_rise = mul_done && !done_prev_q;

    always_comb begin
        state_d       = state_q;
        mul_start_d   = 1'b0;
        mul_a_d       = mul_a_q;
        mul_b_d       = mul_b_q;
        job_tag_d     = job_tag_q;
        out_valid_d   = out_valid_q;
        out_product_d = out_product_q;
        out_tag_d     = out_tag_q;
`ifdef BOOTH_SEQ_TIMEOUT_EN
        out_err_d     = out_err_q;
        wdog_d        = wdog_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    {job_tag_d, mul_a_d, mul_b_d} = fifo_rd_data;
                    mul_start_d = 1'b1;
                    state_d     = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
`ifdef BOOTH_SEQ_TIMEOUT_EN
                wdog_d  = '0;
`endif
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (done_rise) begin
                    out_product_d = mul_product;
                    out_tag_d     = job_tag_q;
                    out_valid_d   = 1'b1;
`ifdef BOOTH_SEQ_TIMEOUT_EN
                    out_err_d     = 1'b0;
`endif
                    state_d       = ST_HOLD;
                end
`ifdef BOOTH_SEQ_TIMEOUT_EN
                else if (wdog_q == WDOG_W'(TIMEOUT_LIMIT)) begin
                    out_product_d = '0;
                    out_tag_d     = job_tag_q;
                    out_valid_d   = 1'b1;
                    out_err_d     = 1'b1;
                    state_d       = ST_HOLD;
                end else begin
                    wdog_d = wdog_q + WDOG_W'(1);
                end
`endif
            end
            ST_HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            mul_start_q   <= 1'b0;
            mul_a_q       <= '0;
            mul_b_q       <= '0;
            job_tag_q     <= '0;
            done_prev_q   <= 1'b0;
            out_valid_q   <= 1'b0;
            out_product_q <= '0;
            out_tag_q     <= '0;
`ifdef BOOTH_SEQ_TIMEOUT_EN
            out_err_q     <= 1'b0;
            wdog_q        <= '0;
`endif
        end else begin
            state_q       <= state_d;
            mul_start_q   <= mul_start_d;
            mul_a_q       <= mul_a_d;
            mul_b_q       <= mul_b_d;
            job_tag_q     <= job_tag_d;
            done_prev_q   <= mul_done;
            out_valid_q   <= out_valid_d;
            out_product_q <= out_product_d;
            out_tag_q     <= out_tag_d;
`ifdef BOOTH_SEQ_TIMEOUT_EN
            out_err_q     <= out_err_d;
            wdog_q        <= wdog_d;
`endif
        end
    end

    assign in_ready    = !fifo_full;
    assign mul_start   = mul_start_q;
    assign mul_a       = mul_a_q;
    assign mul_b       = mul_b_q;
    assign out_valid   = out_valid_q;
    assign out_product = out_product_q;
    assign out_tag     = out_tag_q;
`ifdef BOOTH_SEQ_TIMEOUT_EN
    assign out_err     = out_err_q;
`else
    assign out_err     = 1'b0;
`endif
    assign busy        = (state_q != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_booth_job_sequencer.sv
// ---------------------------------------------------------------------------
// tb_booth_job_sequencer
// Directed bench for booth_job_sequencer with a behavioural multiplier model
// (configurable done delay, stale-done hold, never-done). Expected values are
// hand-computed constants. Timeout scenario built only with
// BOOTH_SEQ_TIMEOUT_EN.
// ---------------------------------------------------------------------------
module tb_booth_job_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_a;
    logic [7:0]  in_b;
    logic [1:0]  in_tag;
    logic        mul_start;
    logic [7:0]  mul_a;
    logic [7:0]  mul_b;
    logic        mul_done;
    logic [15:0] mul_product;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_product;
    logic [1:0]  out_tag;
    logic        out_err;
    logic        busy;

    int check_count = 0;
    int error_count = 0;
    int cyc = 0;
    int start_count = 0;
    int last_accept_cyc = 0;

    // Multiplier model controls.
    int model_delay = 9;
    int model_stale = 0;
    bit model_never = 1'b0;
    int model_cnt;
    int model_hold;

    booth_job_sequencer dut (
        .clock       (clock),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_tag      (in_tag),
        .mul_start   (mul_start),
        .mul_a       (mul_a),
        .mul_b       (mul_b),
        .mul_done    (mul_done),
        .mul_product (mul_product),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_product (out_product),
        .out_tag     (out_tag),
        .out_err     (out_err),
        .busy        (busy)
    );

    always #5 clock = ~clock;

    // Cycle counter and launch monitor; a pulse seen here belongs to cycle cyc.
    always @(posedge clock) begin
        if (mul_start === 1'b1) begin
            start_count = start_count + 1;
        end
        cyc = cyc + 1;
    end

    // Multiplier model: done drops at start (or model_stale cycles later) and
    // rises model_delay cycles after the start cycle; it then stays high.
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            mul_done    <= 1'b0;
            mul_product <= '0;
            model_cnt   <= 0;
            model_hold  <= 0;
        end else if (mul_start) begin
            mul_product <= 16'($signed({{8{mul_a[7]}}, mul_a}) * $signed({{8{mul_b[7]}}, mul_b}));
            model_cnt   <= model_delay - 1;
            model_hold  <= model_stale;
            if (model_stale == 0) begin
                mul_done <= 1'b0;
            end
        end else begin
            if (model_hold > 0) begin
                model_hold <= model_hold - 1;
                if (model_hold == 1) begin
                    mul_done <= 1'b0;
                end
            end
            if (model_cnt > 0) begin
                model_cnt <= model_cnt - 1;
                if (model_cnt == 1 && !model_never) begin
                    mul_done <= 1'b1;
                end
            end
        end
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_count++;
        if (got !== exp) begin
            error_count++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Offers one job starting at a negedge; returns at the negedge after it
    // has been accepted.
    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic [1:0] tag);
        int n = 0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_tag   = tag;
        while (in_ready !== 1'b1 && n < 200) begin
            @(negedge clock);
            n++;
        end
        checkOutput("push_accepted", {31'd0, in_ready}, 32'd1);
        last_accept_cyc = cyc;
        @(posedge clock);
        @(negedge clock);
        in_valid = 1'b0;
    endtask

    task automatic waitForStart(input string tag, input int max_cycles);
        int n = 0;
        while (mul_start !== 1'b1 && n < max_cycles) begin
            @(negedge clock);
            n++;
        end
        checkOutput(tag, {31'd0, mul_start}, 32'd1);
    endtask

    task automatic waitForOut(input string tag, input int max_cycles);
        int n = 0;
        while (out_valid !== 1'b1 && n < max_cycles) begin
            @(negedge clock);
            n++;
        end
        checkOutput(tag, {31'd0, out_valid}, 32'd1);
    endtask

    // Completes one output handshake and returns at the following negedge.
    task automatic acceptResult();
        out_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        out_ready = 1'b0;
    endtask

    task automatic checkResetValues(input string p);
        checkOutput({p, "_in_ready"},    {31'd0, in_ready},    32'd1);
        checkOutput({p, "_mul_start"},   {31'd0, mul_start},   32'd0);
        checkOutput({p, "_mul_a"},       {24'd0, mul_a},       32'd0);
        checkOutput({p, "_mul_b"},       {24'd0, mul_b},       32'd0);
        checkOutput({p, "_out_valid"},   {31'd0, out_valid},   32'd0);
        checkOutput({p, "_out_product"}, {16'd0, out_product}, 32'd0);
        checkOutput({p, "_out_tag"},     {30'd0, out_tag},     32'd0);
        checkOutput({p, "_out_err"},     {31'd0, out_err},     32'd0);
        checkOutput({p, "_busy"},        {31'd0, busy},        32'd0);
    endtask

    // Global time limit so the run always terminates.
    initial begin
        #500000;
        $display("[TB] FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "[TB] global timeout");
    end

    initial begin
        int s;
        int sc;
        int h;
        int bad;
        logic [15:0] exp_prod [5];
        logic [1:0]  exp_tag  [5];
        logic [7:0]  va [5];
        logic [7:0]  vb [5];

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_tag    = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge clock);
        checkResetValues("rst");
        reset = 1'b0;
        @(negedge clock);

        // Single job: 3 * -2 = -6, done 9 cycles after start.
        $display("[TB] single job");
        model_delay = 9;
        sc = start_count;
        applyStimulus(8'd3, 8'hFE, 2'd1);
        h = last_accept_cyc;
        waitForStart("t1_start_seen", 10);
        s = cyc;
        checkOutput("t1_start_latency", s - h, 32'd2);
        checkOutput("t1_mul_a", {24'd0, mul_a}, 32'h03);
        checkOutput("t1_mul_b", {24'd0, mul_b}, 32'hFE);
        waitForOut("t1_out_seen", 40);
        checkOutput("t1_out_latency", cyc - s, 32'd10);
        checkOutput("t1_product", {16'd0, out_product}, 32'hFFFA);
        checkOutput("t1_tag", {30'd0, out_tag}, 32'd1);
        checkOutput("t1_err", {31'd0, out_err}, 32'd0);
        checkOutput("t1_start_pulses", start_count - sc, 32'd1);
        acceptResult();
        checkOutput("t1_valid_cleared", {31'd0, out_valid}, 32'd0);

        // Back-to-back: five jobs offered on consecutive cycles.
        $display("[TB] back-to-back");
        model_delay = 4;
        out_ready   = 1'b1;
        va[0] = 8'd10;  vb[0] = 8'd20;  exp_prod[0] = 16'h00C8; exp_tag[0] = 2'd0;
        va[1] = 8'hFB;  vb[1] = 8'd7;   exp_prod[1] = 16'hFFDD; exp_tag[1] = 2'd1;
        va[2] = 8'h80;  vb[2] = 8'h80;  exp_prod[2] = 16'h4000; exp_tag[2] = 2'd2;
        va[3] = 8'h7F;  vb[3] = 8'h80;  exp_prod[3] = 16'hC080; exp_tag[3] = 2'd3;
        va[4] = 8'd0;   vb[4] = 8'd55;  exp_prod[4] = 16'h0000; exp_tag[4] = 2'd0;
        sc = cyc;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(va[i], vb[i], exp_tag[i]);
        end
        checkOutput("b2b_no_stall", cyc - sc, 32'd5);
        checkOutput("b2b_in_ready_full", {31'd0, in_ready}, 32'd0);
        checkOutput("b2b_busy", {31'd0, busy}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            waitForOut($sformatf("b2b_out_seen%0d", i), 40);
            checkOutput($sformatf("b2b_product%0d", i), {16'd0, out_product}, {16'd0, exp_prod[i]});
            checkOutput($sformatf("b2b_tag%0d", i), {30'd0, out_tag}, {30'd0, exp_tag[i]});
            @(negedge clock);
        end
        checkOutput("b2b_idle", {31'd0, busy}, 32'd0);

        // Stale done: done stays high 2 cycles past the next start.
        $display("[TB] stale done");
        model_stale = 2;
        model_delay = 6;
        applyStimulus(8'hFD, 8'hFC, 2'd2);
        waitForStart("t3_start_seen", 10);
        s = cyc;
        waitForOut("t3_out_seen", 40);
        checkOutput("t3_out_latency", cyc - s, 32'd7);
        checkOutput("t3_product", {16'd0, out_product}, 32'h000C);
        checkOutput("t3_tag", {30'd0, out_tag}, 32'd2);
        @(negedge clock);
        model_stale = 0;
        out_ready   = 1'b0;

        // Backpressure: result held 10 cycles with two jobs still queued.
        $display("[TB] backpressure");
        model_delay = 4;
        applyStimulus(8'd2, 8'd3, 2'd1);
        applyStimulus(8'hFF, 8'hFF, 2'd2);
        applyStimulus(8'd100, 8'hFD, 2'd3);
        waitForOut("t4_out_seen", 40);
        checkOutput("t4_product0", {16'd0, out_product}, 32'h0006);
        checkOutput("t4_tag0", {30'd0, out_tag}, 32'd1);
        sc  = start_count;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (out_valid !== 1'b1 || out_product !== 16'h0006 || out_tag !== 2'd1) begin
                bad++;
            end
        end
        checkOutput("t4_held_stable", bad, 32'd0);
        checkOutput("t4_no_start_while_held", start_count - sc, 32'd0);
        h = cyc;
        acceptResult();
        waitForStart("t4_next_start_seen", 10);
        checkOutput("t4_handshake_to_start", cyc - h, 32'd2);
        waitForOut("t4_out1_seen", 40);
        checkOutput("t4_product1", {16'd0, out_product}, 32'h0001);
        checkOutput("t4_tag1", {30'd0, out_tag}, 32'd2);
        acceptResult();
        waitForOut("t4_out2_seen", 40);
        checkOutput("t4_product2", {16'd0, out_product}, 32'hFED4);
        checkOutput("t4_tag2", {30'd0, out_tag}, 32'd3);
        acceptResult();

        // Reset while waiting on a job with two more queued.
        $display("[TB] reset mid-WAIT");
        model_never = 1'b1;
        out_ready   = 1'b1;
        applyStimulus(8'd5, 8'd5, 2'd0);
        applyStimulus(8'd6, 8'd6, 2'd1);
        applyStimulus(8'd7, 8'd7, 2'd2);
        repeat (3) @(negedge clock);
        checkOutput("t5_busy_before", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        #1;
        checkResetValues("t5");
        @(negedge clock);
        reset       = 1'b0;
        model_never = 1'b0;
        sc  = start_count;
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            if (out_valid !== 1'b0) begin
                bad++;
            end
        end
        checkOutput("t5_no_output_after", bad, 32'd0);
        checkOutput("t5_no_start_after", start_count - sc, 32'd0);
        checkOutput("t5_idle_after", {31'd0, busy}, 32'd0);
        out_ready = 1'b0;

`ifdef BOOTH_SEQ_TIMEOUT_EN
        // Watchdog: done never arrives; WAIT entered the cycle after start.
        $display("[TB] timeout");
        model_never = 1'b1;
        applyStimulus(8'd9, 8'd9, 2'd3);
        waitForStart("t6_start_seen", 10);
        s = cyc;
        waitForOut("t6_out_seen", 120);
        checkOutput("t6_out_latency", cyc - (s + 1), 32'd64);
        checkOutput("t6_err", {31'd0, out_err}, 32'd1);
        checkOutput("t6_product", {16'd0, out_product}, 32'd0);
        checkOutput("t6_tag", {30'd0, out_tag}, 32'd3);
        acceptResult();
        model_never = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule

// File: doc/booth_job_sequencer.md
# booth_job_sequencer

Front-end job sequencer for the 8-bit Booth multiplier. Accepts operand pairs over a valid/ready stream, buffers them in a small FIFO, launches each job on the multiplier with a single-cycle `mul_start`, detects completion from the multiplier's `done` level, and returns the 16-bit product with its tag on a valid/ready output stream. It sits directly upstream of the multiplier controller/datapath and also consumes the multiplier's result.

## Interface
- `WIDTH`, 8: operand width; product is 2*WIDTH.
- `DEPTH`, 4: operand FIFO entries (power of two, >= 2).
- `TAG_W`, 2: width of the job tag carried alongside each job.
- `clock`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  operand pair offered.
- `in_ready`  out  1  FIFO can accept (= not full).
- `in_a`, `in_b`  in  WIDTH  signed multiplicand / multiplier.
- `in_tag`  in  TAG_W  job tag.
- `mul_start`  out  1  one-cycle launch pulse to the multiplier.
- `mul_a`, `mul_b`  out  WIDTH  operands held stable from launch until completion.
- `mul_done`  in  1  multiplier done level.
- `mul_product`  in  2*WIDTH  multiplier result, valid when `mul_done` rises.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer accepts result.
- `out_product`  out  2*WIDTH  signed product.
- `out_tag`  out  TAG_W  tag of the returned job.
- `out_err`  out  1  result produced by timeout (0 when timeout is compiled out).
- `busy`  out  1  FSM not in IDLE or FIFO not empty.

## Operation
- Input push when `in_valid && in_ready`. FIFO write/read pointers wrap modulo DEPTH; count is log2(DEPTH)+1 bits.
- FSM states: IDLE, LAUNCH, WAIT, HOLD.
- IDLE: if FIFO not empty, pop head into `mul_a`/`mul_b`/tag register and go to LAUNCH.
- LAUNCH: `mul_start`=1 for exactly this cycle; go to WAIT.
- WAIT: completion is the rising edge of `mul_done` (registered previous value is 0, current value is 1). Because `done` may still be high from the previous job when the launch occurs, a level alone is never treated as completion. On completion, capture `mul_product` into `out_product`, set `out_err`=0, and go to HOLD.
- HOLD: `out_valid`=1, and outputs stay stable until `out_ready`. When the result is accepted, go to IDLE. A new job is never launched while a result is held.
- Push and pop in the same cycle are allowed at any occupancy except full, where only the pop occurs because `in_ready`=0 that cycle.
- `mul_a`/`mul_b` change only on a pop.

## Timing
- Reset values: `in_ready`=1, `mul_start`=0, `mul_a`=`mul_b`=0, `out_valid`=0, `out_product`=0, `out_tag`=0, `out_err`=0, `busy`=0. The FIFO is emptied, the FSM is in IDLE, and the registered `mul_done` is 0.
- An input accepted into an empty, idle block at cycle t pops at t+1 and issues `mul_start` at t+2.
- `out_valid` asserts the cycle after the `mul_done` rising edge is sampled.
- The minimum gap between the output handshake and the next `mul_start` is 2 cycles (IDLE, then LAUNCH).
- Reset mid-job drops the in-flight job and all queued jobs. No output is produced for them.

## Configuration
- `BOOTH_SEQ_TIMEOUT_EN` defined: a watchdog counter clears on LAUNCH and increments in WAIT. If it reaches 63 without a `mul_done` rising edge, the FSM moves to HOLD with `out_product`=0 and `out_err`=1.
- `BOOTH_SEQ_TIMEOUT_EN` undefined: no watchdog, WAIT waits indefinitely, and `out_err` is tied to 0.

## Structure
- Shared package `booth_pkg`: FSM state enum, default `WIDTH`/`DEPTH`/`TAG_W` constants, and the timeout limit (63).
- One sub-module, `booth_op_fifo`: a synchronous FIFO holding `{tag, a, b}` with push/pop/full/empty outputs. The sequencer FSM, edge detector and watchdog live in the top module.

## Test plan
- Single job: a=3, b=-2 (8'hFE), tag=1, with the bench multiplier model asserting done 9 cycles after start. Required: `out_product`=16'hFFFA, `out_tag`=1, and `mul_start` high for exactly 1 cycle.
- Back-to-back: push 5 jobs with `out_ready`=1. Required: `in_ready` drops after the 4th entry is queued (with the 1st already popped, the 5th waits), and results return in order with matching tags.
- Stale done: the model holds `mul_done`=1 across the next start and drops it 2 cycles later. Required: no completion until the following rising edge.
- Backpressure: hold `out_ready`=0 for 10 cycles with jobs queued. Required: results stay stable, and no `mul_start` pulses until the result is accepted.
- Reset mid-WAIT with 2 jobs queued. Required: all outputs return to their reset values, and no result is emitted after reset is released.
- With `BOOTH_SEQ_TIMEOUT_EN`: the model never asserts done. Required: `out_valid` arrives 64 cycles after WAIT is entered, with `out_err`=1 and `out_product`=0.
